// File: rtl/drain_arb_pkg.sv
// Shared types and helpers for the FIFO drain arbiter: FSM state, skid depth,
// and the round-robin lane picker.
package drain_arb_pkg;

  typedef enum logic {IDLE, GRANT} drain_st_t;

  localparam int SKID_DEPTH = 2;

  // The picker works on a fixed-width request vector; callers zero-extend.
  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First requesting lane at or above ptr, wrapping n_lane-1 -> 0.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input int unsigned ptr,
                                       input int unsigned n_lane);
    rr_pick_t    r;
    int unsigned lane;
    r = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      if (k < n_lane && !r.found) begin
        lane = ptr + k;
        if (lane >= n_lane) lane = lane - n_lane;
        if (req[lane]) begin
          r.found = 1'b1;
          r.idx   = RR_IDX_W'(lane);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry {lane, data} queue between the lane read path and the output
// valid/ready port; reports occupancy for the issue credit.
module drain_skid_buf
  import drain_arb_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic [1:0]   occ,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data
);

  logic [W-1:0] mem [SKID_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop;

  assign pop   = valid && ready;
  assign valid = (occ != 2'd0);
  assign data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst read scheduler over N ss_fifo_sync lanes, merging their
// 1-cycle-latency read data into one lane-tagged valid/ready stream.
module fifo_drain_arbiter
  import drain_arb_pkg::*;
#(
  parameter  int N_LANE = 4,
  parameter  int BW_D   = 8,
  parameter  int BURST  = 4,
  localparam int BW_L   = $clog2(N_LANE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_LANE-1:0]      ln_rd_rdy,
  output logic [N_LANE-1:0]      ln_rd_en,
  input  logic [N_LANE*BW_D-1:0] ln_rd_do,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BW_D-1:0]        out_data,
  output logic [BW_L-1:0]        out_lane
);

  localparam int BW_B = $clog2(BURST + 1);

  drain_st_t            st, st_nxt;
  logic [BW_L-1:0]      gnt, gnt_nxt;
  logic [BW_L-1:0]      rr_ptr, rr_ptr_nxt;
  logic [BW_B-1:0]      burst, burst_nxt;
  logic                 infl;
  logic [BW_L-1:0]      infl_lane;
  logic                 issue;
  logic [BW_L-1:0]      issue_lane;
  logic                 pop;
  logic                 credit;
  logic [1:0]           occ;
  logic [1:0]           cnt;
  logic [BW_D-1:0]      cap_data;
  logic [BW_L+BW_D-1:0] skid_q;
  rr_pick_t             pick;

  function automatic logic [BW_L-1:0] lane_inc(input logic [BW_L-1:0] l);
    return (l == BW_L'(N_LANE - 1)) ? '0 : l + 1'b1;
  endfunction

  // A word is "owed" from issue until it leaves the skid buffer, so a read may
  // only go out when a slot is guaranteed by the time its data lands.
  assign pop    = out_valid && out_ready;
  assign cnt    = occ + {1'b0, infl};
  assign credit = (cnt < 2'(SKID_DEPTH)) || ((cnt == 2'(SKID_DEPTH)) && pop);
  assign pick   = rr_pick(RR_MAX'(ln_rd_rdy), 32'(rr_ptr), N_LANE);

  always_comb begin
    st_nxt     = st;
    gnt_nxt    = gnt;
    rr_ptr_nxt = rr_ptr;
    burst_nxt  = burst;
    issue      = 1'b0;
    issue_lane = gnt;
    ln_rd_en   = '0;
    case (st)
      IDLE: begin
        if (pick.found && credit) begin
          issue      = 1'b1;
          issue_lane = BW_L'(pick.idx);
          gnt_nxt    = issue_lane;
          burst_nxt  = BW_B'(1);
          if (BURST == 1) rr_ptr_nxt = lane_inc(issue_lane);
          else            st_nxt     = GRANT;
        end
      end
      GRANT: begin
        issue     = ln_rd_rdy[gnt] && credit && (burst < BW_B'(BURST));
        burst_nxt = burst + BW_B'(issue);
        // Credit starvation alone keeps the grant; only an empty lane or a
        // completed burst hands it on.
        if (!ln_rd_rdy[gnt] || (burst_nxt == BW_B'(BURST))) begin
          st_nxt     = IDLE;
          rr_ptr_nxt = lane_inc(gnt);
        end
      end
      default: st_nxt = IDLE;
    endcase
    ln_rd_en[issue_lane] = issue;
  end

  always_comb begin
    cap_data = '0;
    for (int unsigned i = 0; i < N_LANE; i++) begin
      if (infl_lane == BW_L'(i)) cap_data = ln_rd_do[i*BW_D +: BW_D];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      burst     <= '0;
      infl      <= 1'b0;
      infl_lane <= '0;
    end else begin
      st        <= st_nxt;
      gnt       <= gnt_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst     <= burst_nxt;
      infl      <= issue;
      infl_lane <= issue_lane;
    end
  end

  drain_skid_buf #(
    .W(BW_L + BW_D)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (infl),
    .push_data ({infl_lane, cap_data}),
    .occ       (occ),
    .valid     (out_valid),
    .ready     (out_ready),
    .data      (skid_q)
  );

  assign {out_lane, out_data} = skid_q;

endmodule
